// File: rtl/vanilla_sb_multi_tracker.sv
// rtl/vanilla_sb_multi_tracker.sv - per-register long-latency op tracker with issue-to-clear latency
// Optional stall-cycle attribution per category: define VANILLA_SB_TRACKER_STALL_ATTR_EN.

module vanilla_sb_multi_tracker #(
  parameter int num_rf_p    = 2,
  parameter int reg_els_p   = 32,
  parameter int num_cat_p   = 8,
  parameter int lat_width_p = 16,
  localparam int rf_id_width_lp    = (num_rf_p > 1) ? $clog2(num_rf_p) : 1,
  localparam int reg_addr_width_lp = (reg_els_p > 1) ? $clog2(reg_els_p) : 1,
  localparam int cat_width_lp      = (num_cat_p > 1) ? $clog2(num_cat_p) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      flush_i,
  input  logic                                      stall_id_i,
  input  logic                                      stall_all_i,
  input  logic                                      issue_v_i,
  input  logic [rf_id_width_lp-1:0]                 issue_rf_i,
  input  logic [reg_addr_width_lp-1:0]              issue_rd_i,
  input  logic [cat_width_lp-1:0]                   issue_cat_i,
  input  logic [num_rf_p-1:0]                       clear_v_i,
  input  logic [num_rf_p*reg_addr_width_lp-1:0]     clear_id_i,
  output logic [num_rf_p*reg_els_p*num_cat_p-1:0]   pending_o,
  output logic [num_rf_p-1:0]                       retire_v_o,
  output logic [num_rf_p*reg_addr_width_lp-1:0]     retire_rd_o,
  output logic [num_rf_p*cat_width_lp-1:0]          retire_cat_o,
  output logic [num_rf_p*lat_width_p-1:0]           retire_lat_o,
  output logic                                      protocol_err_o,
  input  logic                                      stall_sb_i,
  input  logic [rf_id_width_lp-1:0]                 stall_rf_i,
  input  logic [reg_addr_width_lp-1:0]              stall_reg_i,
  output logic [num_cat_p*lat_width_p-1:0]          stall_cnt_o
);

  logic [num_rf_p-1:0][reg_els_p-1:0]                    valid_w;
  logic [num_rf_p-1:0][reg_els_p-1:0][cat_width_lp-1:0]  cat_w;
  logic [num_rf_p-1:0][reg_els_p-1:0][lat_width_p-1:0]   age_w;

  logic [num_rf_p-1:0][reg_addr_width_lp-1:0] clr_id;
  logic [num_rf_p-1:0]                        clr_ok;
  logic [num_rf_p-1:0]                        clr_bad;

  logic issue_acc;
  logic issue_rf_ok;
  logic issue_en;
  logic issue_tgt_valid;
  logic issue_tgt_clear;
  logic issue_overwrite;
  logic stall_err;
  logic err_set;

  assign issue_acc   = issue_v_i & ~stall_id_i & ~stall_all_i & ~flush_i;
  assign issue_rf_ok = int'(issue_rf_i) < num_rf_p;
  assign issue_en    = issue_acc & issue_rf_ok;

  // A same-cycle clear of the target retires the old op, so it is not an overwrite.
  assign issue_tgt_valid = issue_rf_ok & valid_w[issue_rf_i][issue_rd_i];
  assign issue_tgt_clear = issue_rf_ok & clear_v_i[issue_rf_i] & (clr_id[issue_rf_i] == issue_rd_i);
  assign issue_overwrite = issue_en & issue_tgt_valid & ~issue_tgt_clear;

  for (genvar f = 0; f < num_rf_p; f++) begin : g_rf
    assign clr_id[f]  = clear_id_i[f*reg_addr_width_lp +: reg_addr_width_lp];
    assign clr_ok[f]  = clear_v_i[f] & valid_w[f][clr_id[f]];
    assign clr_bad[f] = clear_v_i[f] & ~valid_w[f][clr_id[f]];

    for (genvar r = 0; r < reg_els_p; r++) begin : g_reg
      logic                    valid_q;
      logic [cat_width_lp-1:0] cat_q;
      logic [lat_width_p-1:0]  age_q;
      logic                    issue_hit;
      logic                    clear_hit;

      assign issue_hit = issue_en && (issue_rf_i == rf_id_width_lp'(f))
                         && (issue_rd_i == reg_addr_width_lp'(r));
      assign clear_hit = clr_ok[f] && (clr_id[f] == reg_addr_width_lp'(r));

      // Issue has priority so a collision leaves the new op installed.
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          valid_q <= 1'b0;
          cat_q   <= '0;
          age_q   <= '0;
        end else if (issue_hit) begin
          valid_q <= 1'b1;
          cat_q   <= issue_cat_i;
          age_q   <= lat_width_p'(1);
        end else if (clear_hit) begin
          valid_q <= 1'b0;
          age_q   <= '0;
        end else if (valid_q && (age_q != '1)) begin
          age_q   <= age_q + 1'b1;
        end
      end

      assign valid_w[f][r] = valid_q;
      assign cat_w[f][r]   = cat_q;
      assign age_w[f][r]   = age_q;
      assign pending_o[(f*reg_els_p + r)*num_cat_p +: num_cat_p] =
        valid_q ? (num_cat_p'(1) << cat_q) : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      retire_v_o   <= '0;
      retire_rd_o  <= '0;
      retire_cat_o <= '0;
      retire_lat_o <= '0;
    end else begin
      retire_v_o <= clr_ok;
      for (int f = 0; f < num_rf_p; f++) begin
        if (clr_ok[f]) begin
          retire_rd_o[f*reg_addr_width_lp +: reg_addr_width_lp] <= clr_id[f];
          retire_cat_o[f*cat_width_lp +: cat_width_lp]          <= cat_w[f][clr_id[f]];
          retire_lat_o[f*lat_width_p +: lat_width_p]            <= age_w[f][clr_id[f]];
        end
      end
    end
  end

`ifdef VANILLA_SB_TRACKER_STALL_ATTR_EN
  logic                    stall_rf_ok;
  logic                    stall_hit;
  logic [cat_width_lp-1:0] stall_cat;

  assign stall_rf_ok = int'(stall_rf_i) < num_rf_p;
  assign stall_hit   = stall_sb_i & stall_rf_ok & valid_w[stall_rf_i][stall_reg_i];
  assign stall_cat   = cat_w[stall_rf_i][stall_reg_i];
  assign stall_err   = stall_sb_i & ~stall_hit;

  for (genvar c = 0; c < num_cat_p; c++) begin : g_cnt
    logic [lat_width_p-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        cnt_q <= '0;
      end else if (stall_hit && (stall_cat == cat_width_lp'(c)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign stall_cnt_o[c*lat_width_p +: lat_width_p] = cnt_q;
  end
`else
  logic unused_stall;

  assign unused_stall = ^{stall_sb_i, stall_rf_i, stall_reg_i};
  assign stall_err    = 1'b0;
  assign stall_cnt_o  = '0;
`endif

  assign err_set = (issue_acc & ~issue_rf_ok) | issue_overwrite | (|clr_bad) | stall_err;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      protocol_err_o <= 1'b0;
    end else if (err_set) begin
      protocol_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vanilla_sb_multi_tracker.sv
// tb/tb_vanilla_sb_multi_tracker.sv - table, directed and random checks of vanilla_sb_multi_tracker
// Stall-attribution checks follow VANILLA_SB_TRACKER_STALL_ATTR_EN.

module tb_vanilla_sb_multi_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, flush, stall_id, stall_all, issue_v;
  logic [0:0]   issue_rf;
  logic [4:0]   issue_rd;
  logic [2:0]   issue_cat;
  logic [1:0]   clear_v;
  logic [9:0]   clear_id;
  logic         stall_sb;
  logic [0:0]   stall_rf;
  logic [4:0]   stall_reg;

  logic [511:0] pending;
  logic [1:0]   retire_v;
  logic [9:0]   retire_rd;
  logic [5:0]   retire_cat;
  logic [31:0]  retire_lat;
  logic         perr;
  logic [127:0] stall_cnt;

  logic [511:0] unused_pend4;
  logic [1:0]   unused_rv4;
  logic [9:0]   unused_rd4;
  logic [5:0]   unused_cat4;
  logic [7:0]   lat4;
  logic         unused_err4;
  logic [31:0]  unused_sc4;

  vanilla_sb_multi_tracker dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .stall_id_i(stall_id), .stall_all_i(stall_all),
    .issue_v_i(issue_v), .issue_rf_i(issue_rf), .issue_rd_i(issue_rd), .issue_cat_i(issue_cat),
    .clear_v_i(clear_v), .clear_id_i(clear_id), .pending_o(pending), .retire_v_o(retire_v),
    .retire_rd_o(retire_rd), .retire_cat_o(retire_cat), .retire_lat_o(retire_lat),
    .protocol_err_o(perr), .stall_sb_i(stall_sb), .stall_rf_i(stall_rf), .stall_reg_i(stall_reg),
    .stall_cnt_o(stall_cnt)
  );

  vanilla_sb_multi_tracker #(.lat_width_p(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .stall_id_i(stall_id), .stall_all_i(stall_all),
    .issue_v_i(issue_v), .issue_rf_i(issue_rf), .issue_rd_i(issue_rd), .issue_cat_i(issue_cat),
    .clear_v_i(clear_v), .clear_id_i(clear_id), .pending_o(unused_pend4), .retire_v_o(unused_rv4),
    .retire_rd_o(unused_rd4), .retire_cat_o(unused_cat4), .retire_lat_o(lat4),
    .protocol_err_o(unused_err4), .stall_sb_i(stall_sb), .stall_rf_i(stall_rf),
    .stall_reg_i(stall_reg), .stall_cnt_o(unused_sc4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: entries remember their issue cycle; latency is a cycle difference.
  bit       m_valid [2][32];
  int       m_cat   [2][32];
  int       m_iss   [2][32];
  bit       m_err;
  bit [1:0] e_rv;
  int       e_rd [2], e_cat [2], e_lat [2], e_lat4 [2];
  int       m_scnt [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_pend(input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL pending_o: got %h expected %h", act, exp);
    end
  endtask

  function automatic logic [511:0] exp_pending();
    logic [511:0] v;
    v = '0;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 32; r++)
        if (m_valid[f][r]) v[(f*32 + r)*8 + m_cat[f][r]] = 1'b1;
    return v;
  endfunction

  task automatic model_edge();
    bit acc;
    int rf, rd, id, lat;
    if (reset) begin
      for (int f = 0; f < 2; f++) begin
        for (int r = 0; r < 32; r++) m_valid[f][r] = 1'b0;
        e_rd[f] = 0; e_cat[f] = 0; e_lat[f] = 0; e_lat4[f] = 0;
      end
      for (int c = 0; c < 8; c++) m_scnt[c] = 0;
      e_rv  = 2'b00;
      m_err = 1'b0;
      return;
    end
    acc = issue_v && !stall_id && !stall_all && !flush;
    rf  = int'(issue_rf);
    rd  = int'(issue_rd);
    if (acc && m_valid[rf][rd] && !(clear_v[rf] && int'(clear_id[rf*5 +: 5]) == rd)) m_err = 1'b1;
`ifdef VANILLA_SB_TRACKER_STALL_ATTR_EN
    if (stall_sb) begin
      if (m_valid[stall_rf][stall_reg]) begin
        if (m_scnt[m_cat[stall_rf][stall_reg]] < 65535) m_scnt[m_cat[stall_rf][stall_reg]]++;
      end else begin
        m_err = 1'b1;
      end
    end
`endif
    for (int f = 0; f < 2; f++) begin
      e_rv[f] = 1'b0;
      id = int'(clear_id[f*5 +: 5]);
      if (clear_v[f]) begin
        if (m_valid[f][id]) begin
          e_rv[f]   = 1'b1;
          e_rd[f]   = id;
          e_cat[f]  = m_cat[f][id];
          lat       = cyc - m_iss[f][id];
          e_lat[f]  = (lat > 65535) ? 65535 : lat;
          e_lat4[f] = (lat > 15) ? 15 : lat;
          m_valid[f][id] = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    if (acc) begin
      m_valid[rf][rd] = 1'b1;
      m_cat[rf][rd]   = int'(issue_cat);
      m_iss[rf][rd]   = cyc;
    end
  endtask

  task automatic check_outputs();
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("retire_v[%0d]", f), 64'(retire_v[f]), 64'(e_rv[f]));
      chk($sformatf("retire_rd[%0d]", f), 64'(retire_rd[f*5 +: 5]), 64'(e_rd[f]));
      chk($sformatf("retire_cat[%0d]", f), 64'(retire_cat[f*3 +: 3]), 64'(e_cat[f]));
      chk($sformatf("retire_lat[%0d]", f), 64'(retire_lat[f*16 +: 16]), 64'(e_lat[f]));
      chk($sformatf("retire_lat_w4[%0d]", f), 64'(lat4[f*4 +: 4]), 64'(e_lat4[f]));
    end
    chk("protocol_err", 64'(perr), 64'(m_err));
    chk_pend(pending, exp_pending());
`ifdef VANILLA_SB_TRACKER_STALL_ATTR_EN
    for (int c = 0; c < 8; c++)
      chk($sformatf("stall_cnt[%0d]", c), 64'(stall_cnt[c*16 +: 16]), 64'(m_scnt[c]));
`else
    chk("stall_cnt_zero", 64'(|stall_cnt), 64'(0));
`endif
  endtask

  task automatic idle_inputs();
    flush = 1'b0; stall_id = 1'b0; stall_all = 1'b0; issue_v = 1'b0;
    issue_rf = 1'b0; issue_rd = 5'd0; issue_cat = 3'd0; clear_v = 2'b00; clear_id = 10'd0;
    stall_sb = 1'b0; stall_rf = 1'b0; stall_reg = 5'd0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic issue(input int rf, input int rd, input int cat);
    idle_inputs();
    issue_v = 1'b1; issue_rf = 1'(rf); issue_rd = 5'(rd); issue_cat = 3'(cat);
  endtask

  typedef struct {
    logic       issue_v, stall_id, stall_all, flush;
    logic [0:0] rf;
    logic [4:0] rd;
    logic [2:0] cat;
    logic [1:0] clr_v;
    logic [4:0] cid0, cid1;
    int         chk_rf, chk_rd;
    logic [7:0] exp_pend;
    logic [1:0] exp_rv;
    int         exp_lat0, exp_lat1;
    logic       exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 3'd1, 2'b00, 5'd0, 5'd0, 0, 7, 8'h00, 2'b00, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 3'd1, 2'b00, 5'd0, 5'd0, 0, 7, 8'h00, 2'b00, 0, 0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 3'd1, 2'b00, 5'd0, 5'd0, 0, 7, 8'h00, 2'b00, 0, 0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 3'd1, 2'b00, 5'd0, 5'd0, 0, 7, 8'h02, 2'b00, 0, 0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 3'd6, 2'b00, 5'd0, 5'd0, 1, 7, 8'h40, 2'b00, 0, 0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'b11, 5'd7, 5'd7, 0, 7, 8'h00, 2'b11, 2, 1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'b01, 5'd9, 5'd0, 1, 7, 8'h00, 2'b00, 0, 0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 5'd0, 5'd0, 0, 9, 8'h00, 2'b00, 0, 0, 1'b1};

    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Gating, dual clear and idle-clear error.
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      issue_v = tbl[i].issue_v; stall_id = tbl[i].stall_id; stall_all = tbl[i].stall_all;
      flush = tbl[i].flush; issue_rf = tbl[i].rf; issue_rd = tbl[i].rd; issue_cat = tbl[i].cat;
      clear_v = tbl[i].clr_v; clear_id = {tbl[i].cid1, tbl[i].cid0};
      step();
      chk($sformatf("tbl%0d_pend", i),
          64'(pending[(tbl[i].chk_rf*32 + tbl[i].chk_rd)*8 +: 8]), 64'(tbl[i].exp_pend));
      chk($sformatf("tbl%0d_rv", i), 64'(retire_v), 64'(tbl[i].exp_rv));
      chk($sformatf("tbl%0d_err", i), 64'(perr), 64'(tbl[i].exp_err));
      if (tbl[i].exp_rv[0]) chk($sformatf("tbl%0d_lat0", i), 64'(retire_lat[15:0]), 64'(tbl[i].exp_lat0));
      if (tbl[i].exp_rv[1]) chk($sformatf("tbl%0d_lat1", i), 64'(retire_lat[31:16]), 64'(tbl[i].exp_lat1));
    end

    // Latency 37, and saturation to 15 in the 4-bit instance.
    do_reset();
    issue(0, 5, 2);
    step();
    chk("lat_pend_first", 64'(pending[(0*32 + 5)*8 +: 8]), 64'h04);
    idle_inputs();
    for (int i = 0; i < 36; i++) begin
      step();
      chk("lat_pend_hold", 64'(pending[(0*32 + 5)*8 +: 8]), 64'h04);
    end
    clear_v = 2'b01; clear_id = 10'd5;
    step();
    chk("lat_rv", 64'(retire_v), 64'b01);
    chk("lat_rd", 64'(retire_rd[4:0]), 64'd5);
    chk("lat_cat", 64'(retire_cat[2:0]), 64'd2);
    chk("lat_value", 64'(retire_lat[15:0]), 64'd37);
    chk("lat_sat_w4", 64'(lat4[3:0]), 64'd15);
    chk("lat_pend_drop", 64'(pending[(0*32 + 5)*8 +: 8]), 64'h00);
    idle_inputs();
    step();
    chk("lat_pulse_one_cycle", 64'(retire_v), 64'b00);
    chk("lat_field_hold", 64'(retire_lat[15:0]), 64'd37);

    // Issue/clear collision on rf1 rd3.
    issue(1, 3, 1);
    step();
    idle_inputs();
    for (int i = 0; i < 19; i++) step();
    issue(1, 3, 4);
    clear_v = 2'b10; clear_id = {5'd3, 5'd0};
    step();
    chk("col_rv", 64'(retire_v), 64'b10);
    chk("col_cat", 64'(retire_cat[5:3]), 64'd1);
    chk("col_lat", 64'(retire_lat[31:16]), 64'd20);
    chk("col_pend_new", 64'(pending[(1*32 + 3)*8 +: 8]), 64'h10);
    chk("col_no_err", 64'(perr), 64'd0);
    idle_inputs();
    clear_v = 2'b10; clear_id = {5'd3, 5'd0};
    step();
    chk("col_new_cat", 64'(retire_cat[5:3]), 64'd4);
    chk("col_new_lat", 64'(retire_lat[31:16]), 64'd1);

    // Reset discards pending entries without retiring them.
    issue(0, 1, 0); step();
    issue(1, 2, 5); step();
    issue(0, 3, 7); step();
    idle_inputs();
    reset = 1'b1;
    step();
    chk("rst_pend_zero", 64'(|pending), 64'd0);
    chk("rst_rv_zero", 64'(retire_v), 64'd0);
    reset = 1'b0;
    clear_v = 2'b11; clear_id = {5'd2, 5'd1};
    step();
    chk("rst_no_retire", 64'(retire_v), 64'd0);
    chk("rst_clear_idle_err", 64'(perr), 64'd1);

    do_reset();
`ifdef VANILLA_SB_TRACKER_STALL_ATTR_EN
    issue(0, 2, 3);
    step();
    idle_inputs();
    stall_sb = 1'b1; stall_rf = 1'b0; stall_reg = 5'd2;
    for (int i = 0; i < 12; i++) step();
    idle_inputs();
    step();
    for (int c = 0; c < 8; c++)
      chk($sformatf("stall_attr[%0d]", c), 64'(stall_cnt[c*16 +: 16]), (c == 3) ? 64'd12 : 64'd0);
    chk("stall_attr_no_err", 64'(perr), 64'd0);
`else
    idle_inputs();
    stall_sb = 1'b1; stall_rf = 1'b0; stall_reg = 5'd2;
    for (int i = 0; i < 12; i++) step();
    chk("stall_ignored_cnt", 64'(|stall_cnt), 64'd0);
    chk("stall_ignored_err", 64'(perr), 64'd0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      idle_inputs();
      reset     = ($urandom_range(0, 199) == 0);
      issue_v   = ($urandom_range(0, 1) == 1);
      stall_id  = ($urandom_range(0, 9) == 0);
      stall_all = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      issue_rf  = 1'($urandom_range(0, 1));
      issue_rd  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      issue_cat = 3'($urandom_range(0, 7));
      clear_v   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      clear_id  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      stall_sb  = ($urandom_range(0, 7) == 0);
      stall_rf  = 1'($urandom_range(0, 1));
      stall_reg = 5'($urandom_range(0, 3));
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
